// File: rtl/adder_word_sequencer.sv
// rtl/adder_word_sequencer.sv - multi-word add/sub sequencer for a shared external 16-bit adder
// Two requesters arbitrated round-robin; one 16-bit slice per cycle, LSW first, carry registered.
module adder_word_sequencer #(
   parameter int WORDS = 4,
   localparam int W = 16 * WORDS,
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid_i,
   output logic          req0_ready_o,
   input  logic          req0_sub_i,
   input  logic [W-1:0]  req0_a_i,
   input  logic [W-1:0]  req0_b_i,
   input  logic          req1_valid_i,
   output logic          req1_ready_o,
   input  logic          req1_sub_i,
   input  logic [W-1:0]  req1_a_i,
   input  logic [W-1:0]  req1_b_i,
   output logic [15:0]   add_a_o,
   output logic [15:0]   add_b_o,
   output logic          add_cin_o,
   input  logic [15:0]   add_sum_i,
   input  logic          add_cout_i,
   output logic          resp_valid_o,
   input  logic          resp_ready_i,
   output logic          resp_id_o,
   output logic [W-1:0]  resp_sum_o,
   output logic          resp_cout_o,
   output logic          resp_ovf_o
);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t                   state_q, state_d;
   logic                     rr_q, rr_d;
   logic                     carry_q, carry_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [WORDS-1:0][15:0]   a_q, a_d;
   logic [WORDS-1:0][15:0]   b_q, b_d;
   logic                     sub_q, sub_d;
   logic [WORDS-1:0][15:0]   sum_q, sum_d;
   logic                     cout_q, cout_d;
   logic                     ovf_q, ovf_d;
   logic                     id_q, id_d;
   logic                     gnt0, gnt1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         id_q    <= id_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      carry_d      = carry_q;
      idx_d        = idx_q;
      a_d          = a_q;
      b_d          = b_q;
      sub_d        = sub_q;
      sum_d        = sum_q;
      cout_d       = cout_q;
      ovf_d        = ovf_q;
      id_d         = id_q;
      req0_ready_o = 1'b0;
      req1_ready_o = 1'b0;
      add_a_o      = '0;
      add_b_o      = '0;
      add_cin_o    = 1'b0;
      // rr_q names the requester that wins when both are valid
      gnt0 = req0_valid_i && (!req1_valid_i || !rr_q);
      gnt1 = req1_valid_i && (!req0_valid_i || rr_q);

      unique case (state_q)
         IDLE: begin
            if (gnt0 || gnt1) begin
               req0_ready_o = gnt0;
               req1_ready_o = gnt1;
               a_d          = gnt1 ? req1_a_i : req0_a_i;
               b_d          = gnt1 ? req1_b_i : req0_b_i;
               sub_d        = gnt1 ? req1_sub_i : req0_sub_i;
               carry_d      = gnt1 ? req1_sub_i : req0_sub_i;
               idx_d        = '0;
               id_d         = gnt1;
               rr_d         = !gnt1;
               state_d      = ADD;
            end
         end
         ADD: begin
            add_a_o        = a_q[idx_q];
            add_b_o        = b_q[idx_q] ^ {16{sub_q}};
            add_cin_o      = carry_q;
            sum_d[idx_q]   = add_sum_i;
            carry_d        = add_cout_i;
            idx_d          = idx_q + IW'(1);
            if (idx_q == IW'(WORDS - 1)) begin
               cout_d  = add_cout_i;
               ovf_d   = (add_a_o[15] == add_b_o[15]) && (add_sum_i[15] != add_a_o[15]);
               state_d = DONE;
            end
         end
         DONE: begin
            if (resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign resp_valid_o = (state_q == DONE);
   assign resp_id_o    = id_q;
   assign resp_sum_o   = sum_q;
   assign resp_cout_o  = cout_q;
   assign resp_ovf_o   = ovf_q;

endmodule
